// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/freeze sequencing with MDU occupancy tracking.
// Optional bubble counter enabled by macro HAZARD_STALL_CNT_EN.
`default_nettype none

module hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int REG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_reads_hilo,
  input  logic             id_is_mdu,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_mdu_start,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             pwrite1,
  output logic             if_id_flush,
  output logic             pwrite2,
  output logic             pipe_hold,
  output logic             mdu_busy,
  output logic [15:0]      stall_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam logic [3:0] LAT_C   = 4'(MDU_LAT);

  logic [0:0] state_q, state_d;
  logic [3:0] mdu_cnt_q, mdu_cnt_d;
  logic       mdu_active;
  logic       accept;
  logic       load_use;
  logic       mdu_use;
  logic       stall_bubble;

  assign mdu_active = (mdu_cnt_q != 4'd0);
  assign accept     = ex_mdu_start & ~mem_busy & (state_q == ST_IDLE);
  assign load_use   = ex_memread & (ex_rt != '0) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign mdu_use    = mdu_active & (id_reads_hilo | id_is_mdu);

  // Bubble cycles that are not caused by a branch squash; kept free of rst_n.
  assign stall_bubble = ~mem_busy & ~ex_branch_taken & (load_use | mdu_use);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mdu_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_BUSY;
          mdu_cnt_d = LAT_C;
        end
      end
      ST_BUSY: begin
        // Counts down regardless of mem_busy; a start here is ignored.
        if (mdu_cnt_q <= 4'd1) begin
          state_d   = ST_IDLE;
          mdu_cnt_d = 4'd0;
        end else begin
          mdu_cnt_d = mdu_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mdu_cnt_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    pwrite1     = 1'b0;
    if_id_flush = 1'b0;
    pwrite2     = 1'b0;
    pipe_hold   = 1'b0;
    mdu_busy    = 1'b0;
    if (rst_n) begin
      mdu_busy = mdu_active;
      if (mem_busy) begin
        pipe_hold = 1'b1;
        pwrite2   = 1'b1;
      end else if (ex_branch_taken) begin
        pc_write    = 1'b1;
        pwrite1     = 1'b1;
        if_id_flush = 1'b1;
      end else if (!(load_use | mdu_use)) begin
        pc_write = 1'b1;
        pwrite1  = 1'b1;
        pwrite2  = 1'b1;
      end
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_bubble && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= 16'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`else
  logic unused_stall;
  assign unused_stall = stall_bubble;
  assign stall_count  = 16'h0;
`endif

endmodule

`default_nettype wire
